// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: issues one data-memory transaction per accepted
// request, aligns/extends load data, and holds busy until the done pulse.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  func3,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [31:0] load_q;
  logic        err_q;
  logic [15:0] tmo_cnt;

  logic        accept;
  logic        bad_req;
  logic        timeout_hit;

  // Loads allow byte/half/word with signed and unsigned narrow forms; stores only signed-encoded sizes.
  function automatic logic legal_f3(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Size lives in func3[1:0]; only called meaningfully for legal encodings.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Replicate the store value across lanes so memory picks it up under any strobe.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] b);
    case (f3[1:0])
      2'b00:   return {4{b[7:0]}};
      2'b01:   return {2{b[15:0]}};
      default: return b;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Pick the addressed byte/half out of the returned word and extend per func3[2].
  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
    logic signed [7:0]  byte_v;
    logic signed [15:0] half_v;
    byte_v = rdata[{a, 3'b000} +: 8];
    half_v = rdata[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{byte_v[7]}}, byte_v};
      3'b100:  return {24'd0, byte_v};
      3'b001:  return {{16{half_v[15]}}, half_v};
      3'b101:  return {16'd0, half_v};
      default: return rdata;
    endcase
  endfunction

  assign accept      = req_valid && (mem_read || mem_write);
  assign bad_req     = (mem_read && mem_write) || !legal_f3(mem_write, func3) ||
                       misaligned(func3, alu_result[1:0]);
  assign timeout_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Next-state decode for the request/grant/response handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = bad_req ? DONE : REQ;
      REQ:  if (dmem_gnt) state_next = WAIT;
      WAIT: if (dmem_rvalid || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request capture, timeout counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      func3_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state  <= state_next;
      load_q <= '0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          addr_q  <= alu_result;
          func3_q <= func3;
          we_q    <= mem_write && !bad_req;
          wdata_q <= (mem_write && !bad_req) ? store_wdata(func3, store_data) : 32'd0;
          wstrb_q <= (mem_write && !bad_req) ? store_wstrb(func3, alu_result[1:0]) : 4'd0;
          err_q   <= bad_req;
          tmo_cnt <= '0;
        end
        WAIT: begin
          if (dmem_rvalid) begin
            if (!we_q) load_q <= load_align(func3_q, addr_q[1:0], dmem_rdata);
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = err_q;
  assign load_data  = load_q;
  assign dmem_req   = (state == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a small memory responder.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, mem_read, mem_write;
  logic [31:0] alu_result, store_data;
  logic [2:0]  func3;
  logic        busy, done, err;
  logic [31:0] load_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int failures = 0;

  int          r_lat, r_reqc;
  logic [31:0] r_ld, r_addr, r_wdata, r_after_ld;
  logic [3:0]  r_wstrb;
  logic        r_we, r_err, r_saw, r_stable, r_busy_ok, r_fin, r_after_done, r_after_busy;

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .alu_result(alu_result), .store_data(store_data), .func3(func3),
    .busy(busy), .done(done), .err(err), .load_data(load_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction: gnt after gw REQ cycles, rvalid after rw WAIT cycles (rw<0: never).
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] sd,
                       input logic [2:0] f3, input int gw, input int rw, input logic [31:0] rdat);
    int w;
    logic granted;
    r_lat = 0; r_reqc = 0; r_saw = 0; r_stable = 1; r_busy_ok = 1; r_fin = 0;
    r_err = 0; r_ld = 0; r_addr = 0; r_wdata = 0; r_wstrb = 0; r_we = 0;
    r_after_done = 1; r_after_busy = 1; r_after_ld = 32'hFFFF_FFFF;
    req_valid = 1; mem_read = rd; mem_write = wr; alu_result = a; store_data = sd; func3 = f3;
    @(posedge clk); #1;
    req_valid = 0; mem_read = 0; mem_write = 0;
    granted = 0; w = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      dmem_gnt = 0; dmem_rvalid = 0;
      if (!busy) r_busy_ok = 0;
      if (done) begin
        r_lat = cyc; r_ld = load_data; r_err = err; r_fin = 1;
        break;
      end
      if (dmem_req) begin
        r_reqc++;
        if (!r_saw) begin
          r_saw = 1; r_addr = dmem_addr; r_wdata = dmem_wdata; r_wstrb = dmem_wstrb; r_we = dmem_we;
        end else if (dmem_addr !== r_addr || dmem_wdata !== r_wdata ||
                     dmem_wstrb !== r_wstrb || dmem_we !== r_we) begin
          r_stable = 0;
        end
        if (r_reqc > gw) begin dmem_gnt = 1; granted = 1; end
      end else if (granted) begin
        w++;
        if (rw >= 0 && w > rw) begin dmem_rvalid = 1; dmem_rdata = rdat; end
      end
      @(posedge clk); #1;
    end
    dmem_gnt = 0; dmem_rvalid = 0;
    check("op_done_seen", r_fin, 1);
    if (r_fin) begin
      @(posedge clk); #1;
      r_after_done = done; r_after_busy = busy; r_after_ld = load_data;
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; mem_read = 0; mem_write = 0; alu_result = 0; store_data = 0; func3 = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_req", dmem_req, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_ld", load_data, 0);
    rst = 0;
    @(posedge clk); #1;

    // LW best case
    do_op(1, 0, 32'h0000_1004, 0, 3'b010, 0, 0, 32'hDEAD_BEEF);
    check("lw_lat", r_lat, 3);
    check("lw_addr", r_addr, 32'h0000_1004);
    check("lw_wstrb", r_wstrb, 4'b0000);
    check("lw_we", r_we, 0);
    check("lw_ld", r_ld, 32'hDEAD_BEEF);
    check("lw_err", r_err, 0);
    check("lw_busy", r_busy_ok, 1);
    check("lw_done_1cyc", r_after_done, 0);
    check("lw_busy_after", r_after_busy, 0);
    check("lw_ld_after", r_after_ld, 0);

    // Narrow loads
    do_op(1, 0, 32'h0000_1003, 0, 3'b000, 0, 0, 32'h80FF_1234);
    check("lb_ld", r_ld, 32'hFFFF_FF80);
    check("lb_addr", r_addr, 32'h0000_1000);
    do_op(1, 0, 32'h0000_1003, 0, 3'b100, 0, 0, 32'h80FF_1234);
    check("lbu_ld", r_ld, 32'h0000_0080);
    do_op(1, 0, 32'h0000_1002, 0, 3'b101, 0, 0, 32'h80FF_1234);
    check("lhu_ld", r_ld, 32'h0000_80FF);
    do_op(1, 0, 32'h0000_1002, 0, 3'b001, 0, 0, 32'h80FF_1234);
    check("lh_ld", r_ld, 32'hFFFF_80FF);
    do_op(1, 0, 32'h0000_1001, 0, 3'b000, 0, 0, 32'h80FF_1234);
    check("lb1_ld", r_ld, 32'h0000_0012);

    // Stores
    do_op(0, 1, 32'h0000_2002, 32'h1234_ABCD, 3'b001, 0, 0, 32'hFFFF_FFFF);
    check("sh_we", r_we, 1);
    check("sh_addr", r_addr, 32'h0000_2000);
    check("sh_wdata", r_wdata, 32'hABCD_ABCD);
    check("sh_wstrb", r_wstrb, 4'b1100);
    check("sh_ld", r_ld, 0);
    check("sh_err", r_err, 0);
    check("sh_lat", r_lat, 3);
    do_op(0, 1, 32'h0000_3001, 32'h0000_00A5, 3'b000, 0, 0, 32'hFFFF_FFFF);
    check("sb_wdata", r_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", r_wstrb, 4'b0010);
    do_op(0, 1, 32'h0000_4000, 32'h1122_3344, 3'b010, 0, 0, 32'hFFFF_FFFF);
    check("sw_wdata", r_wdata, 32'h1122_3344);
    check("sw_wstrb", r_wstrb, 4'b1111);

    // Error requests: no memory access, done+err one cycle after acceptance
    do_op(1, 0, 32'h0000_1001, 0, 3'b010, 0, 0, 0);
    check("mis_req", r_saw, 0);
    check("mis_err", r_err, 1);
    check("mis_lat", r_lat, 1);
    check("mis_busy_after", r_after_busy, 0);
    do_op(1, 0, 32'h0000_1000, 0, 3'b011, 0, 0, 0);
    check("f3_req", r_saw, 0);
    check("f3_err", r_err, 1);
    check("f3_lat", r_lat, 1);
    do_op(1, 1, 32'h0000_1000, 0, 3'b010, 0, 0, 0);
    check("rw_req", r_saw, 0);
    check("rw_err", r_err, 1);
    check("rw_lat", r_lat, 1);
    do_op(0, 1, 32'h0000_1000, 32'h55, 3'b100, 0, 0, 0);
    check("sf3_err", r_err, 1);
    do_op(0, 1, 32'h0000_1001, 32'h55, 3'b001, 0, 0, 0);
    check("shmis_err", r_err, 1);
    check("shmis_req", r_saw, 0);

    // Grant withheld 5 cycles
    do_op(1, 0, 32'h0000_5008, 0, 3'b010, 5, 0, 32'h0BAD_F00D);
    check("stall_reqc", r_reqc, 6);
    check("stall_stable", r_stable, 1);
    check("stall_lat", r_lat, 8);
    check("stall_ld", r_ld, 32'h0BAD_F00D);
    check("stall_err", r_err, 0);

    // Timeout with no rvalid
    do_op(1, 0, 32'h0000_6000, 0, 3'b010, 0, -1, 0);
    check("tmo_err", r_err, 1);
    check("tmo_lat", r_lat, 6);
    check("tmo_ld", r_ld, 0);
    check("tmo_busy_after", r_after_busy, 0);

    // Reset during WAIT, then a stray rvalid
    req_valid = 1; mem_read = 1; alu_result = 32'h0000_7000; func3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 0; mem_read = 0;
    check("rw_in_req", dmem_req, 1);
    dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0;
    check("rw_in_wait_busy", busy, 1);
    check("rw_in_wait_req", dmem_req, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("wrst_busy", busy, 0);
    check("wrst_done", done, 0);
    check("wrst_err", err, 0);
    check("wrst_req", dmem_req, 0);
    check("wrst_addr", dmem_addr, 0);
    check("wrst_we", dmem_we, 0);
    check("wrst_wdata", dmem_wdata, 0);
    check("wrst_ld", load_data, 0);
    dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_rvalid = 0;
    check("wrst_nodone1", done, 0);
    check("wrst_idle", busy, 0);
    @(posedge clk); #1;
    check("wrst_nodone2", done, 0);

    do_op(1, 0, 32'h0000_1008, 0, 3'b010, 0, 0, 32'hCAFE_F00D);
    check("post_rst_lat", r_lat, 3);
    check("post_rst_ld", r_ld, 32'hCAFE_F00D);
    check("post_rst_err", r_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
